// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round count, S-box, GF(2^8) helpers
// and state-byte to bus-bit mapping helpers.
package aes_pkg;

  localparam int unsigned NR          = 10;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned KEY_SCHED_W = BLOCK_W * (NR + 1);
  localparam int unsigned ROUND_W     = 4;

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  // Standard AES S-box; entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * 32'(b) -: 8];
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // MSB position of state byte s(r,c) within a 128-bit bus.
  function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
    return 127 - 8 * (4 * c + r);
  endfunction

  // Round key k out of the expanded schedule; key 0 is the top slice.
  function automatic logic [127:0] round_key(input logic [KEY_SCHED_W-1:0] w,
                                             input int unsigned k);
    return w[KEY_SCHED_W - 1 - BLOCK_W * k -: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes128_cipher_if.sv
// Request/response bundle of the AES-128 core.
//   start : one-cycle encrypt request      in   : plaintext block
//   word  : expanded key schedule (11 keys) out  : ciphertext (held)
//   busy  : block in progress              done : one-cycle completion pulse
interface aes128_cipher_if;
  import aes_pkg::*;

  logic                   start;
  logic [BLOCK_W-1:0]     in;
  logic [KEY_SCHED_W-1:0] word;
  logic [BLOCK_W-1:0]     out;
  logic                   busy;
  logic                   done;

  modport master (output start, in, word, input out, busy, done);
  modport slave  (input start, in, word, output out, busy, done);
endinterface

// File: rtl/aes128_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey.
//   state       : current state        round_key  : key for this round
//   final_round : skip MixColumns      next_state : round result
module aes128_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               final_round,
  output logic [BLOCK_W-1:0] next_state
);

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] mixed;

  // SubBytes fused with ShiftRows: s'(r,c) = S(s(r, c+r mod 4)).
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[byte_msb(r, c) -: 8] = sbox(state[byte_msb(r, (c + r) % 4) -: 8]);
      end
    end
  end

  // MixColumns with the [02 03 01 01] circulant.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = shifted[byte_msb(0, c) -: 8];
      a1 = shifted[byte_msb(1, c) -: 8];
      a2 = shifted[byte_msb(2, c) -: 8];
      a3 = shifted[byte_msb(3, c) -: 8];
      mixed[127 - 32 * c -: 32] = {
        gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
        a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
        a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
        gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)
      };
    end
  end

  assign next_state = (final_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes128_cipher.sv
// Iterative AES-128 encryption core, one round per clock, using an
// externally supplied expanded key schedule.
//   clk : rising-edge clock    rst : asynchronous active-high reset
//   bus : request/response bundle (slave side)
module aes128_cipher
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  aes128_cipher_if.slave   bus
);

  phase_t             phase;
  logic [BLOCK_W-1:0] state;
  logic [ROUND_W-1:0] round;
  logic [BLOCK_W-1:0] key_sel;
  logic [BLOCK_W-1:0] next_state;
  logic               final_round;

  // Round counter doubles as key index; it is 0 while idle, so the same mux
  // supplies the initial AddRoundKey key.
  assign key_sel     = round_key(bus.word, 32'(round));
  assign final_round = (round == ROUND_W'(NR));

  aes128_round u_round (
    .state       (state),
    .round_key   (key_sel),
    .final_round (final_round),
    .next_state  (next_state)
  );

  // Control, state register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_IDLE;
      state    <= '0;
      round    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (bus.start) begin
            state    <= bus.in ^ key_sel;
            round    <= ROUND_W'(1);
            bus.busy <= 1'b1;
            phase    <= PH_RUN;
          end
        end
        PH_RUN: begin
          if (final_round) begin
            bus.out  <= next_state;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            round    <= '0;
            phase    <= PH_IDLE;
          end else begin
            state <= next_state;
            round <= round + ROUND_W'(1);
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_cipher.sv
// Directed testbench for aes128_cipher using FIPS-197 App. B and App. C.1
// vectors with their published key schedules.
module tb_aes128_cipher;
  import aes_pkg::*;

  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [1407:0] W_C = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [1407:0] W_B = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  aes128_cipher_if bus ();

  aes128_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a block for exactly one rising edge; returns at the following
  // falling edge.
  task automatic launch(input logic [127:0] pt, input logic [1407:0] w);
    @(negedge clk);
    bus.in    = pt;
    bus.word  = w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; latency counts edges after the accepting edge.
  // A nonzero 'interfere' pulses start with in=0 at that cycle.
  task automatic wait_done(input int interfere, input logic [127:0] held,
                           output int lat, output bit held_ok, output bit busy_ok);
    lat     = 0;
    held_ok = 1'b1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == interfere) begin
        bus.start = 1'b1;
        bus.in    = '0;
      end else if (interfere != 0 && i == interfere + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.out !== held) held_ok = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // Watch n cycles with no request; count done pulses and out changes.
  task automatic idle_watch(input int n, input logic [127:0] exp,
                            output int pulses, output bit stable);
    pulses = 0;
    stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
      if (bus.out !== exp) stable = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bit held_ok, busy_ok, stable;
    int pulses;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.word  = '0;
    #1;
    check("reset_out",  bus.out,        128'h0);
    check("reset_busy", 128'(bus.busy), 128'h0);
    check("reset_done", 128'(bus.done), 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // App. C.1
    launch(PT_C, W_C);
    wait_done(0, 128'h0, lat, held_ok, busy_ok);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_out", bus.out, CT_C);
    check("c1_busy_at_done", 128'(bus.busy), 128'h0);
    check("c1_busy_during", 128'(busy_ok), 128'h1);
    check("c1_out_held", 128'(held_ok), 128'h1);
    @(posedge clk); #1;
    check("c1_done_one_cycle", 128'(bus.done), 128'h0);

    // App. B with an ignored start while busy
    launch(PT_B, W_B);
    wait_done(4, CT_C, lat, held_ok, busy_ok);
    check("b_latency", 128'(lat), 128'd10);
    check("b_out", bus.out, CT_B);
    check("b_prev_out_held", 128'(held_ok), 128'h1);
    idle_watch(14, CT_B, pulses, stable);
    check("b_extra_done", 128'(pulses), 128'h0);
    check("b_out_stable", 128'(stable), 128'h1);
    check("b_idle_busy", 128'(bus.busy), 128'h0);

    // Back-to-back: App. C.1 then App. B started in the done cycle
    launch(PT_C, W_C);
    wait_done(0, CT_B, lat, held_ok, busy_ok);
    check("b2b_first_latency", 128'(lat), 128'd10);
    check("b2b_first_out", bus.out, CT_C);
    bus.in    = PT_B;
    bus.word  = W_B;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_accept_busy", 128'(bus.busy), 128'h1);
    wait_done(0, CT_C, lat, held_ok, busy_ok);
    check("b2b_second_latency", 128'(lat), 128'd10);
    check("b2b_second_out", bus.out, CT_B);
    check("b2b_first_out_held", 128'(held_ok), 128'h1);

    // Asynchronous reset at round 5
    launch(PT_C, W_C);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_out",  bus.out,        128'h0);
    check("rst_mid_busy", 128'(bus.busy), 128'h0);
    check("rst_mid_done", 128'(bus.done), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(12, 128'h0, pulses, stable);
    check("rst_no_done", 128'(pulses), 128'h0);
    check("rst_out_zero", 128'(stable), 128'h1);
    launch(PT_C, W_C);
    wait_done(0, 128'h0, lat, held_ok, busy_ok);
    check("post_rst_latency", 128'(lat), 128'd10);
    check("post_rst_out", bus.out, CT_C);

    // Output stability with changing inputs and no start
    @(negedge clk);
    bus.in   = PT_B;
    bus.word = W_B;
    idle_watch(6, CT_C, pulses, stable);
    bus.in   = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    bus.word = {11{128'h0f0e0d0c0b0a09080706050403020100}};
    idle_watch(6, CT_C, pulses, stable);
    check("stable_no_done", 128'(pulses), 128'h0);
    check("stable_out", bus.out, CT_C);
    check("stable_idle_busy", 128'(bus.busy), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
